// File: rtl/fft_stage_reader.sv
`timescale 1ns/1ps
// Read-side sequencer for the in-place radix-2 FFT: walks every stage issuing one butterfly read per cycle.
// Pair is presented one cycle after its read; between stages it stalls until write-back reports stage_done.
module fft_stage_reader #(
  parameter int FFT_N          = 10,
  parameter int FFT_DW         = 16,
  parameter int STAGE_COUNT_BW = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [STAGE_COUNT_BW-1:0] fft_stage,
  output logic                      rd_en,
  output logic [FFT_N-2:0]          rd_addr,
  output logic [FFT_N-2:0]          tw_addr,
  input  logic [2*FFT_DW-1:0]       rd_even_data,
  input  logic [2*FFT_DW-1:0]       rd_odd_data,
  input  logic                      stage_done,
  output logic                      oact,
  output logic [1:0]                octrl,
  output logic [FFT_N-2:0]          output_memory_address,
  output logic [2*FFT_DW-1:0]       output_A,
  output logic [2*FFT_DW-1:0]       output_B
);

  localparam int KW = FFT_N - 1;
  localparam logic [KW-1:0] K_MAX = '1;
  localparam logic [STAGE_COUNT_BW-1:0] LAST_STAGE = STAGE_COUNT_BW'(FFT_N - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FIN
  } state_t;

  state_t state;

  logic [KW-1:0]             tw_mask;
  logic [STAGE_COUNT_BW-1:0] tw_shift;
  logic [1:0]                ictrl;

  // Twiddle index: low 'stage' bits of k, left-justified into the ROM address.
  always_comb begin
    tw_mask  = KW'((32'd1 << fft_stage) - 32'd1);
    tw_shift = STAGE_COUNT_BW'(KW) - fft_stage;
    tw_addr  = (rd_addr & tw_mask) << tw_shift;
    ictrl    = {rd_addr == K_MAX, rd_addr == '0};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      fft_stage <= '0;
      rd_addr   <= '0;
      rd_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_ISSUE;
            fft_stage <= '0;
            rd_addr   <= '0;
            rd_en     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_ISSUE: begin
          rd_addr <= rd_addr + 1'b1;
          if (rd_addr == K_MAX) begin
            state <= ST_DRAIN;
            rd_en <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (stage_done) begin
            if (fft_stage == LAST_STAGE) begin
              state <= ST_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= ST_ISSUE;
              fft_stage <= fft_stage + 1'b1;
              rd_addr   <= '0;
              rd_en     <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bank and ROM both answer one cycle after the read, so the presentation stage is a single register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oact                  <= 1'b0;
      octrl                 <= 2'b00;
      output_memory_address <= '0;
    end else begin
      oact                  <= rd_en;
      octrl                 <= rd_en ? ictrl : 2'b00;
      output_memory_address <= rd_addr;
    end
  end

  assign output_A = oact ? rd_even_data : '0;
  assign output_B = oact ? rd_odd_data : '0;

endmodule

// File: tb/tb_fft_stage_reader.sv
`timescale 1ns/1ps
// Bench for fft_stage_reader: transaction-level read-sequence model plus directed literal checks.
module tb_fft_stage_reader;

  localparam int FFT_N = 10;
  localparam int FFT_DW = 16;
  localparam int SBW = 4;
  localparam int KW = FFT_N - 1;
  localparam int NBF = 1 << KW;

  logic              clk;
  logic              reset;
  logic              start;
  logic              stage_done;
  logic [2*FFT_DW-1:0] rd_even_data;
  logic [2*FFT_DW-1:0] rd_odd_data;
  logic              busy;
  logic              done;
  logic [SBW-1:0]    fft_stage;
  logic              rd_en;
  logic [KW-1:0]     rd_addr;
  logic [KW-1:0]     tw_addr;
  logic              oact;
  logic [1:0]        octrl;
  logic [KW-1:0]     output_memory_address;
  logic [2*FFT_DW-1:0] output_A;
  logic [2*FFT_DW-1:0] output_B;

  fft_stage_reader #(.FFT_N(FFT_N), .FFT_DW(FFT_DW), .STAGE_COUNT_BW(SBW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .fft_stage(fft_stage), .rd_en(rd_en), .rd_addr(rd_addr), .tw_addr(tw_addr),
    .rd_even_data(rd_even_data), .rd_odd_data(rd_odd_data), .stage_done(stage_done),
    .oact(oact), .octrl(octrl), .output_memory_address(output_memory_address),
    .output_A(output_A), .output_B(output_B)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_fail = 0;
  int cnt_busy, cnt_rd, cnt_done, cnt_stage;
  int sd_delay [FFT_N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a transform is FFT_N*NBF reads in order; after every NBF reads it waits for stage_done.
  bit m_active, m_wait, m_done, m_prev_en;
  int m_idx, m_prev_k;

  initial begin
    m_active = 0; m_wait = 0; m_done = 0; m_prev_en = 0; m_idx = 0; m_prev_k = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_active = 0; m_wait = 0; m_done = 0; m_prev_en = 0; m_idx = 0; m_prev_k = 0;
      end else begin
        m_prev_en = m_active && !m_wait;
        m_prev_k  = m_idx % NBF;
        if (m_done) m_done = 0;
        else if (!m_active) begin
          if (start) begin m_active = 1; m_idx = 0; m_wait = 0; end
        end else if (!m_wait) begin
          m_idx++;
          if (m_idx % NBF == 0) m_wait = 1;
        end else if (stage_done) begin
          if (m_idx == FFT_N * NBF) begin m_active = 0; m_done = 1; end
          else m_wait = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      int k, s;
      @(negedge clk);
      chk("busy", 64'(busy), 64'(m_active));
      chk("done", 64'(done), 64'(m_done));
      chk("rd_en", 64'(rd_en), 64'(m_active && !m_wait));
      chk("oact", 64'(oact), 64'(m_prev_en));
      if (m_active && !m_wait) begin
        k = m_idx % NBF;
        s = m_idx / NBF;
        chk("rd_addr", 64'(rd_addr), 64'(k));
        chk("tw_addr", 64'(tw_addr), 64'((k & ((1 << s) - 1)) << (KW - s)));
      end
      if (m_active)
        chk("fft_stage", 64'(fft_stage), 64'(m_wait ? (m_idx - 1) / NBF : m_idx / NBF));
      if (m_prev_en) begin
        chk("omaddr", 64'(output_memory_address), 64'(m_prev_k));
        chk("octrl", 64'(octrl), 64'({m_prev_k == NBF - 1, m_prev_k == 0}));
        chk("output_A", 64'(output_A), 64'(rd_even_data));
        chk("output_B", 64'(output_B), 64'(rd_odd_data));
      end
      if (busy) cnt_busy++;
      if (rd_en) cnt_rd++;
      if (done) cnt_done++;
      if (rd_en && rd_addr == 0) cnt_stage++;
    end
  end

  // Bank model: fresh data every cycle.
  initial begin
    rd_even_data = '0;
    rd_odd_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      rd_even_data = $urandom;
      rd_odd_data  = $urandom;
    end
  end

  // Write-back responder: stage_done pulse a per-stage number of cycles after each stage's last read.
  initial begin
    stage_done = 1'b0;
    forever begin
      int d;
      @(negedge clk);
      if (rd_en === 1'b1 && rd_addr === KW'(NBF - 1)) begin
        d = (int'(fft_stage) < FFT_N) ? sd_delay[int'(fft_stage)] : 6;
        repeat (d) @(posedge clk);
        #1 stage_done = 1'b1;
        @(posedge clk);
        #1 stage_done = 1'b0;
      end
    end
  end

  task automatic wait_read(input int stg, input int kk, input string nm);
    int n = 0;
    while (!(rd_en === 1'b1 && int'(fft_stage) == stg && int'(rd_addr) == kk) && n < 20000) begin
      @(posedge clk); #1; n++;
    end
    chk(nm, 64'(rd_en === 1'b1 && int'(fft_stage) == stg && int'(rd_addr) == kk), 64'd1);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done !== 1'b1 && n < 20000) begin
      @(posedge clk); #1; n++;
    end
    chk(nm, 64'(done), 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_rd_en"}, 64'(rd_en), 0);
    chk({tag, "_rd_addr"}, 64'(rd_addr), 0);
    chk({tag, "_tw_addr"}, 64'(tw_addr), 0);
    chk({tag, "_stage"}, 64'(fft_stage), 0);
    chk({tag, "_oact"}, 64'(oact), 0);
    chk({tag, "_octrl"}, 64'(octrl), 0);
    chk({tag, "_omaddr"}, 64'(output_memory_address), 0);
    chk({tag, "_A"}, 64'(output_A), 0);
    chk({tag, "_B"}, 64'(output_B), 0);
  endtask

  task automatic clear_counts();
    cnt_busy = 0; cnt_rd = 0; cnt_done = 0; cnt_stage = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < FFT_N; i++) sd_delay[i] = 6;
    clear_counts();
    #3;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Run 1: stage 0 walk, twiddle points, ignored start/stage_done, full completion.
    clear_counts();
    pulse_start();
    chk("s0_busy", 64'(busy), 1);
    chk("s0_rd_en", 64'(rd_en), 1);
    for (int i = 0; i < NBF; i++) begin
      chk("s0_k", 64'(rd_addr), 64'(i));
      chk("s0_tw", 64'(tw_addr), 0);
      if (i == 1) begin
        chk("s0_oact_first", 64'(oact), 1);
        chk("s0_octrl_first", 64'(octrl), 2'b01);
        chk("s0_omaddr_first", 64'(output_memory_address), 0);
      end
      if (i == 2) chk("s0_octrl_mid", 64'(octrl), 2'b00);
      @(posedge clk); #1;
    end
    chk("s0_drain_rd_en", 64'(rd_en), 0);
    chk("s0_octrl_last", 64'(octrl), 2'b10);
    chk("s0_omaddr_last", 64'(output_memory_address), 511);

    wait_read(1, 100, "reach_s1_k100");
    start = 1'b1;
    stage_done = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stage_done = 1'b0;
    chk("issue_sd_ignored_stage", 64'(fft_stage), 1);
    chk("issue_sd_ignored_k", 64'(rd_addr), 101);

    wait_read(3, 13, "reach_s3_k13");
    chk("tw_s3_k13", 64'(tw_addr), 320);
    wait_read(9, 300, "reach_s9_k300");
    chk("tw_s9_k300", 64'(tw_addr), 300);
    wait_done("run1_done");
    chk("run1_busy_at_done", 64'(busy), 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_single_pulse", 64'(done), 0);
    chk("start_in_done_ignored", 64'(busy), 0);
    chk("run1_busy_cycles", 64'(cnt_busy), 5180);
    chk("run1_reads", 64'(cnt_rd), 5120);
    chk("run1_done_pulses", 64'(cnt_done), 1);
    chk("run1_stages", 64'(cnt_stage), 10);

    // Run 2: long drain stall at stage 2, then reset during stage 5 issue.
    sd_delay[2] = 101;
    clear_counts();
    repeat (2) @(posedge clk); #1;
    pulse_start();
    n = 0;
    while (!(fft_stage === 2 && rd_en === 1'b0 && busy === 1'b1) && n < 20000) begin
      @(posedge clk); #1; n++;
    end
    chk("reach_s2_drain", 64'(fft_stage === 2 && rd_en === 1'b0), 1);
    n = 0;
    while (stage_done !== 1'b1 && n < 500) begin
      @(posedge clk); #2; n++;
    end
    chk("stall_cycles", 64'(n), 100);
    chk("stall_rd_en", 64'(rd_en), 0);
    chk("stall_stage", 64'(fft_stage), 2);
    @(posedge clk); #2;
    chk("post_stall_stage", 64'(fft_stage), 3);
    chk("post_stall_k", 64'(rd_addr), 0);
    chk("post_stall_rd_en", 64'(rd_en), 1);

    wait_read(5, 200, "reach_s5_k200");
    #3 reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    sd_delay[2] = 6;
    repeat (2) @(posedge clk); #1;
    chk("midrst_no_done", 64'(cnt_done), 0);
    chk("midrst_idle", 64'(busy), 0);

    // Run 3: restart after reset must begin at stage 0, k 0 and complete normally.
    clear_counts();
    pulse_start();
    chk("run3_stage", 64'(fft_stage), 0);
    chk("run3_k", 64'(rd_addr), 0);
    chk("run3_rd_en", 64'(rd_en), 1);
    wait_done("run3_done");
    @(posedge clk); #1;
    chk("run3_busy_cycles", 64'(cnt_busy), 5180);
    chk("run3_reads", 64'(cnt_rd), 5120);
    chk("run3_done_pulses", 64'(cnt_done), 1);
    chk("run3_stages", 64'(cnt_stage), 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
